// File: rtl/issue_scheduler.sv
// issue_scheduler: compacting oldest-ready-first issue queue with writeback tag wakeup
package issue_scheduler_pkg;
    typedef struct packed {
        logic       instr_valid;
        logic [7:0] opcode;
        logic [6:0] rob_idx;
        logic [5:0] dst_preg;
        logic [5:0] src1_preg;
        logic [5:0] src2_preg;
    } disp_packet_t;
endpackage

module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WB_PORTS = 2,
    parameter int PREG_W   = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  disp_packet_t                 disp_pkt,
    input  logic                         disp_src1_rdy,
    input  logic                         disp_src2_rdy,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0]   wb_preg,
    output logic                         fire_valid,
    output disp_packet_t                 sched_pkt,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    disp_packet_t     pkt_q [DEPTH];
    disp_packet_t     pkt_d [DEPTH];
    logic [DEPTH-1:0] rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [OW-1:0]    occ_q, occ_d, slot;
    logic [IW-1:0]    sel;
    logic             cand, alloc;

    function automatic logic woke(input logic [PREG_W-1:0] tag);
        woke = 1'b0;
        for (int k = 0; k < WB_PORTS; k++)
            woke = woke | (wb_valid[k] && wb_preg[k*PREG_W +: PREG_W] == tag);
    endfunction

    always_comb begin
        int s;
        cand = 1'b0;
        sel  = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (i < int'(occ_q) && rdy1_q[i] && rdy2_q[i]) begin
                cand = 1'b1;
                sel  = IW'(i);
            end
        fire_valid = cand && !rst && !flush;
        sched_pkt  = fire_valid ? pkt_q[sel] : '0;
        disp_ready = (occ_q < OW'(DEPTH)) && !rst;
        alloc      = disp_valid && disp_ready && !flush;
        slot       = occ_q - OW'(fire_valid);
        // entries above the issued slot move down one, picking up this cycle's wakeups
        for (int i = 0; i < DEPTH; i++) begin
            s         = (fire_valid && i >= int'(sel) && i < DEPTH - 1) ? i + 1 : i;
            pkt_d[i]  = pkt_q[s];
            rdy1_d[i] = rdy1_q[s] | woke(pkt_q[s].src1_preg);
            rdy2_d[i] = rdy2_q[s] | woke(pkt_q[s].src2_preg);
            if (alloc && i == int'(slot)) begin
                pkt_d[i]  = disp_pkt;
                rdy1_d[i] = disp_src1_rdy || disp_pkt.src1_preg == '0 || woke(disp_pkt.src1_preg);
                rdy2_d[i] = disp_src2_rdy || disp_pkt.src2_preg == '0 || woke(disp_pkt.src2_preg);
            end
        end
        occ_d = flush ? '0 : occ_q + OW'(alloc) - OW'(fire_valid);
    end

    always_ff @(posedge clk) begin
        if (rst)
            occ_q <= '0;
        else
            occ_q <= occ_d;
    end

    always_ff @(posedge clk) begin
        pkt_q  <= pkt_d;
        rdy1_q <= rdy1_d;
        rdy2_q <= rdy2_d;
    end

    assign occupancy = occ_q;

    a_no_issue_empty: assert property (@(posedge clk) disable iff (rst) fire_valid |-> occ_q != '0);
    a_no_alloc_full:  assert property (@(posedge clk) disable iff (rst) alloc |-> occ_q != OW'(DEPTH));
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: queue-model scoreboard with directed scenarios and random traffic
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    logic         clk = 0;
    logic         rst = 1;
    logic         flush = 0;
    logic         disp_valid = 0;
    logic         disp_ready;
    disp_packet_t disp_pkt = '0;
    logic         disp_src1_rdy = 0;
    logic         disp_src2_rdy = 0;
    logic [1:0]   wb_valid = 0;
    logic [11:0]  wb_preg = 0;
    logic         fire_valid;
    disp_packet_t sched_pkt;
    logic [3:0]   occupancy;

    issue_scheduler dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pkt(disp_pkt),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .wb_valid(wb_valid), .wb_preg(wb_preg),
        .fire_valid(fire_valid), .sched_pkt(sched_pkt), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {disp_packet_t p; bit r1; bit r2;} ment_t;
    typedef struct {int cyc; bit chk_occ; int occ; bit rdy;} st_t;
    typedef struct {int cyc; disp_packet_t p;} fe_t;

    ment_t mq[$];
    st_t   sq[$];
    fe_t   fq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    logic [6:0] rob_ctr = 0;

    function automatic bit hit(input logic [5:0] t, input bit [1:0] wv, input bit [11:0] wp);
        return (wv[0] && wp[5:0] == t) || (wv[1] && wp[11:6] == t);
    endfunction

    function automatic disp_packet_t mk(input logic [5:0] a, input logic [5:0] b);
        disp_packet_t p;
        p.instr_valid = 1'($urandom);
        p.opcode      = 8'($urandom);
        p.rob_idx     = rob_ctr;
        p.dst_preg    = 6'($urandom);
        p.src1_preg   = a;
        p.src2_preg   = b;
        rob_ctr++;
        return p;
    endfunction

    task automatic drive(input bit r, input bit f, input bit dv, input disp_packet_t p,
                         input bit s1, input bit s2, input bit [1:0] wv, input bit [11:0] wp);
        int  fi;
        bit  rdy_e;
        @(negedge clk);
        rst = r; flush = f; disp_valid = dv; disp_pkt = p;
        disp_src1_rdy = s1; disp_src2_rdy = s2; wb_valid = wv; wb_preg = wp;
        rdy_e = !r && mq.size() < 8;
        sq.push_back('{cyc, cyc > 0, mq.size(), rdy_e});
        fi = -1;
        if (!r && !f)
            for (int i = 0; i < mq.size(); i++)
                if (fi < 0 && mq[i].r1 && mq[i].r2) fi = i;
        if (fi >= 0) fq.push_back('{cyc, mq[fi].p});
        if (r || f) mq.delete();
        else begin
            foreach (mq[i]) begin
                mq[i].r1 |= hit(mq[i].p.src1_preg, wv, wp);
                mq[i].r2 |= hit(mq[i].p.src2_preg, wv, wp);
            end
            if (fi >= 0) mq.delete(fi);
            if (dv && rdy_e)
                mq.push_back('{p, s1 || p.src1_preg == 0 || hit(p.src1_preg, wv, wp),
                                  s2 || p.src2_preg == 0 || hit(p.src2_preg, wv, wp)});
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic disp(input logic [5:0] a, input logic [5:0] b, input bit s1, input bit s2);
        drive(0, 0, 1, mk(a, b), s1, s2, 0, 0);
    endtask

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", n, cyc, act, exp);
        end
    endtask

    always begin
        st_t st;
        fe_t fe;
        @(negedge clk);
        #2;
        if (sq.size() > 0) begin
            st = sq.pop_front();
            if (st.chk_occ) chk("occupancy", int'(occupancy), st.occ);
            chk("disp_ready", int'(disp_ready), int'(st.rdy));
            checks++;
            if (fire_valid === 1'b1) begin
                if (fq.size() > 0 && fq[0].cyc == st.cyc) begin
                    fe = fq.pop_front();
                    if (sched_pkt !== fe.p) begin
                        errors++;
                        $display("FAIL sched_pkt cyc=%0d: got %h expected %h", st.cyc, sched_pkt, fe.p);
                    end
                end else begin
                    errors++;
                    $display("FAIL fire_valid cyc=%0d: got 1 expected 0", st.cyc);
                end
            end else if (fq.size() > 0 && fq[0].cyc == st.cyc) begin
                fe = fq.pop_front();
                errors++;
                $display("FAIL fire_valid cyc=%0d: got %b expected 1 (pkt %h)", st.cyc, fire_valid, fe.p);
            end else if (sched_pkt !== '0) begin
                errors++;
                $display("FAIL idle_pkt cyc=%0d: got %h expected 0", st.cyc, sched_pkt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drive(1, 0, 0, '0, 0, 0, 0, 0);
        drive(1, 0, 1, mk(1, 2), 1, 1, 0, 0);
        // basic ready uop
        disp(3, 4, 1, 1);
        idle(2);
        // older unready uop bypassed, then woken
        disp(5, 0, 0, 1);
        disp(6, 7, 1, 1);
        idle(2);
        drive(0, 0, 0, '0, 0, 0, 2'b01, 12'd5);
        idle(2);
        // fill unready, wake entry 3
        for (int i = 0; i < 8; i++) disp(6'(10 + i), 0, 0, 1);
        disp(40, 41, 1, 1);
        drive(0, 0, 0, '0, 0, 0, 2'b10, {6'd13, 6'd0});
        disp(42, 0, 1, 1);
        idle(2);
        drive(0, 1, 1, mk(1, 1), 1, 1, 0, 0);
        // dispatch/wakeup race on src2
        drive(0, 0, 1, mk(0, 9), 1, 0, 2'b01, 12'd9);
        idle(2);
        // full queue: issue-only cycle, then alloc+issue at 7
        for (int i = 0; i < 8; i++) disp(6'(20 + i), 0, 0, 1);
        drive(0, 0, 1, mk(30, 31), 0, 0, 2'b01, 12'd20);
        drive(0, 0, 1, mk(32, 0), 0, 1, 2'b11, {6'd21, 6'd22});
        disp(33, 0, 1, 1);
        disp(34, 0, 0, 1);
        idle(1);
        // flush with a ready entry at occupancy 5
        drive(0, 1, 0, '0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) disp(6'(50 + i), 0, 0, 1);
        drive(0, 0, 0, '0, 0, 0, 2'b01, 12'd52);
        drive(0, 1, 1, mk(1, 1), 1, 1, 0, 0);
        idle(1);
        // reset mid-fill
        for (int i = 0; i < 3; i++) disp(6'(60 + i), 0, 1, 1);
        drive(1, 0, 1, mk(1, 2), 1, 1, 0, 0);
        drive(1, 0, 1, mk(1, 2), 1, 1, 0, 0);
        idle(2);
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            bit r, f, dv;
            r  = ($urandom % 300) == 0;
            f  = ($urandom % 80) == 0;
            dv = ($urandom % 4) != 0;
            drive(r, f, dv, mk(6'($urandom % 8), 6'($urandom % 8)),
                  ($urandom % 3) == 0, ($urandom % 3) == 0,
                  2'($urandom), {6'($urandom % 8), 6'($urandom % 8)});
        end
        idle(3);
        @(negedge clk);
        #5;
        while (fq.size() > 0) begin
            fe_t fe;
            fe = fq.pop_front();
            checks++;
            errors++;
            $display("FAIL unmatched_fire cyc=%0d: got none expected %h", fe.cyc, fe.p);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
